// File: rtl/led_matrix_scan_ctrl.sv
// Double-buffered 6x6 LED matrix scanner: row-at-a-time PWM drive with blanking between rows.
// Host writes the back buffer; a requested swap is applied only on a frame boundary (or at once when idle).
module led_matrix_scan_ctrl #(
  parameter int BRIGHT_BITS  = 2,
  parameter int SLOT_CYCLES  = 4,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [5:0]             wr_addr,
  input  logic [BRIGHT_BITS-1:0] wr_data,
  output logic                   wr_err,
  input  logic                   swap_req,
  output logic                   swap_done,
  output logic                   frame_start,
  output logic [5:0]             row,
  output logic [5:0]             col
);

  localparam int NPIX = 36;
  localparam int NSLOT = (1 << BRIGHT_BITS) - 1;
  localparam int CMAX = (SLOT_CYCLES > BLANK_CYCLES) ? SLOT_CYCLES : BLANK_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [BRIGHT_BITS-1:0] SLOT_IDX_LAST = BRIGHT_BITS'(NSLOT - 1);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_BLANK} state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BRIGHT_BITS-1:0] slot_q, slot_d;
  logic [2:0]             ridx_q, ridx_d;
  logic                   frame_end;

  logic [BRIGHT_BITS-1:0] buf_a_q [NPIX];
  logic [BRIGHT_BITS-1:0] buf_b_q [NPIX];
  logic [BRIGHT_BITS-1:0] front_w [NPIX];
  logic                   front_sel_q;
  logic                   pend_q, pend_d;
  logic                   swap_done_q, wr_err_q, frame_start_q, frame_start_d;
  logic [5:0]             row_q, row_d, col_q, col_d;
  logic [5:0]             base;
  logic                   wr_fire, addr_ok, do_swap;

  assign wr_ready    = ~pend_q;
  assign wr_err      = wr_err_q;
  assign swap_done   = swap_done_q;
  assign frame_start = frame_start_q;
  assign row         = row_q;
  assign col         = col_q;

  assign wr_fire = wr_valid & wr_ready;
  assign addr_ok = (wr_addr < 6'd36);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      slot_q  <= '0;
      ridx_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      ridx_q  <= ridx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    slot_d    = slot_q;
    ridx_d    = ridx_q;
    frame_end = 1'b0;
    if (!en) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      slot_d  = '0;
      ridx_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_DRIVE;
          cnt_d   = '0;
          slot_d  = '0;
          ridx_d  = '0;
        end
        S_DRIVE: begin
          if (cnt_q == SLOT_LAST) begin
            cnt_d = '0;
            if (slot_q == SLOT_IDX_LAST) begin
              slot_d  = '0;
              state_d = S_BLANK;
            end else begin
              slot_d = slot_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            cnt_d   = '0;
            state_d = S_DRIVE;
            if (ridx_q == 3'd5) begin
              ridx_d    = '0;
              frame_end = 1'b1;
            end else begin
              ridx_d = ridx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NPIX; i++) begin
      front_w[i] = front_sel_q ? buf_b_q[i] : buf_a_q[i];
    end
  end

  // Outputs are computed from the current state so they lag it by one register stage.
  always_comb begin
    row_d         = '0;
    col_d         = '1;
    frame_start_d = 1'b0;
    base          = {3'b000, ridx_q} * 3'd6;
    if (en && state_q == S_DRIVE) begin
      row_d = 6'b000001 << ridx_q;
      for (int c = 0; c < 6; c++) begin
        col_d[c] = ~(front_w[base + 6'(c)] > slot_q);
      end
      frame_start_d = (ridx_q == 3'd0) && (slot_q == '0) && (cnt_q == '0);
    end
  end

  // The front toggles together with the DRIVE(0) state, so the next registered row uses the new buffer.
  assign do_swap = pend_q & ~swap_done_q & (~en | (state_q == S_IDLE) | frame_end);
  assign pend_d  = swap_done_q ? 1'b0 : (pend_q | swap_req);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      front_sel_q   <= 1'b0;
      pend_q        <= 1'b0;
      swap_done_q   <= 1'b0;
      wr_err_q      <= 1'b0;
      frame_start_q <= 1'b0;
      row_q         <= '0;
      col_q         <= '1;
    end else begin
      front_sel_q   <= front_sel_q ^ do_swap;
      pend_q        <= pend_d;
      swap_done_q   <= do_swap;
      wr_err_q      <= wr_fire & ~addr_ok;
      frame_start_q <= frame_start_d;
      row_q         <= row_d;
      col_q         <= col_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NPIX; i++) begin
        buf_a_q[i] <= '0;
        buf_b_q[i] <= '0;
      end
    end else if (wr_fire && addr_ok) begin
      if (front_sel_q) buf_a_q[wr_addr] <= wr_data;
      else             buf_b_q[wr_addr] <= wr_data;
    end
  end

endmodule

// File: doc/led_matrix_scan_ctrl.md
Name: led_matrix_scan_ctrl

Overview:
- Double-buffered scan controller for the 6x6 LED matrix on the FeatherWing.
- Host logic writes per-pixel brightness into a back buffer through a valid/ready port. A swap request promotes that buffer to the displayed front buffer at the next frame boundary.
- The block drives one row at a time with per-pixel PWM, blanks between rows to suppress ghosting, and replaces free-running row/col counters in top-level designs.

Parameters:
- BRIGHT_BITS, 2, bits of brightness per pixel; 0 = off, max = fully on.
- SLOT_CYCLES, 4, clk cycles per PWM slot; must be >= 1.
- BLANK_CYCLES, 2, clk cycles of all-off between rows; must be >= 1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- en  in  1  scan enable; 0 = matrix dark, scanner idle
- wr_valid  in  1  write request
- wr_ready  out  1  write can be accepted this cycle
- wr_addr  in  6  pixel index = row*6 + col, valid range 0..35
- wr_data  in  BRIGHT_BITS  pixel brightness
- wr_err  out  1  one-cycle pulse on an accepted write with wr_addr > 35
- swap_req  in  1  request a front/back buffer exchange
- swap_done  out  1  one-cycle pulse on the cycle the exchange takes effect
- frame_start  out  1  one-cycle pulse, first cycle of row 0 drive
- row  out  6  one-hot, active-high row select
- col  out  6  active-low column enables

Behaviour:
- Reset values:
  - row=0, col=6'b111111, wr_ready=1, wr_err=0, swap_done=0, frame_start=0.
  - Both buffers cleared to 0; front = buffer A; no swap pending; state IDLE.
- Definitions:
  - D = (2^BRIGHT_BITS - 1) * SLOT_CYCLES drive cycles per row.
  - Row period = D + BLANK_CYCLES; frame period = 6 * row period.
- States:
  - IDLE: entered from reset or whenever en=0; outputs dark; counters zero.
  - DRIVE(r): row = 1<<r. For column c, col[c]=0 iff front[r*6+c] > s, where s is the current slot index 0..2^BRIGHT_BITS-2 (slot advances every SLOT_CYCLES).
  - BLANK(r): row=0, col=6'b111111.
- Transitions:
  - IDLE with en=1 goes to DRIVE(0).
  - DRIVE(r) goes to BLANK(r) after D cycles.
  - BLANK(r) goes to DRIVE(r+1) after BLANK_CYCLES.
  - BLANK(5) goes to DRIVE(0). This is the frame boundary.
  - en=0 in any state returns to IDLE on the next clock.
- Outputs row, col and frame_start are registered. The first observed DRIVE(0) cycle appears 2 clocks after en rises from IDLE; frame_start is asserted on exactly that cycle.
- Write port:
  - A handshake completes when wr_valid && wr_ready.
  - The write updates the back buffer, visible to the scanner only after a swap.
  - Address > 35: the handshake still completes, buffer is unchanged, and wr_err pulses the following cycle.
  - Last write wins for repeated addresses.
- Swap:
  - swap_req sets pending. wr_ready=0 while pending.
  - The exchange happens at the frame boundary, or on the next clock if the state is IDLE or en=0. swap_done pulses on that cycle, then pending clears and wr_ready returns to 1.
  - The new front is used from the very first DRIVE(0) cycle of the new frame; a frame never mixes buffers.
  - swap_req while already pending is ignored; only one exchange occurs.
  - swap_req and an accepted write in the same cycle: the write lands in the outgoing back buffer, so it becomes visible after the swap.
  - No copy on swap: the new back buffer holds the previous front contents.
- Reset mid-operation: the asynchronous return to reset values is immediate; any pending swap is discarded.
- Max-brightness pixel is lit for all D cycles; 0 is never lit.

Test Plan (defaults BRIGHT_BITS=2, SLOT_CYCLES=4, BLANK_CYCLES=2 -> D=12, row period 14, frame 84):
- Reset then en=1, no writes -> row walks 000001..100000, each one-hot for 12 cycles with 2 dark cycles between; col stays 111111; frame_start every 84 cycles.
- Write addr 7 (r1,c1) = 3, addr 0 = 1, swap_req -> swap_done at the next frame boundary. In row 0, col[0] is low for 4 of 12 cycles. In row 1, col[1] is low for all 12 cycles. All other col bits stay high.
- swap_req mid-frame, then wr_valid held -> wr_ready=0 until swap_done; the held write then completes on the following cycle into the new back buffer.
- Write addr 40 -> handshake completes, wr_err pulses once, neither buffer changes.
- en=0 during DRIVE(3) with swap pending -> next clock row=0, col=111111; swap_done pulses; re-enable gives frame_start and row 000001 two clocks later.
- Assert rst during DRIVE(2) with swap pending -> outputs immediately at reset values, buffers zero, no swap_done pulse after release.
